// File: rtl/serial_pattern_gen1101_pkg.sv
// Shared definitions for the 1101 serial pattern generator and its detectors.
//   state_t      : generator FSM state encoding
//   PAT_W        : pattern length, shared with the detector bench
//   PATTERN_1101 : default transmitted pattern (sent MSB first)
package detector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GAP,
    ST_SEND,
    ST_DONE
  } state_t;

  localparam int unsigned PAT_W = 4;
  localparam logic [PAT_W-1:0] PATTERN_1101 = 4'b1101;

endpackage

// File: rtl/serial_pattern_gen1101_if.sv
// Control/data bundle between a controller and serial_pattern_gen1101.
//   start      : transmission request (controller -> generator)
//   gap        : zero bits before every pattern copy
//   repeat_cnt : number of pattern copies, 0 treated as 1
//   x          : serial data bit
//   busy       : transmission in progress
//   done       : one-cycle pulse after the last bit
//   bit_valid  : x carries a pattern bit
// The repeat count is named repeat_cnt because "repeat" is a reserved word.
interface serial_pattern_gen1101_if #(
  parameter int unsigned CNT_W = 4
);
  logic             start;
  logic [CNT_W-1:0] gap;
  logic [CNT_W-1:0] repeat_cnt;
  logic             x;
  logic             busy;
  logic             done;
  logic             bit_valid;

  modport master (
    output start, gap, repeat_cnt,
    input  x, busy, done, bit_valid
  );

  modport slave (
    input  start, gap, repeat_cnt,
    output x, busy, done, bit_valid
  );
endinterface

// File: rtl/serial_pattern_gen1101_shifter.sv
// serial_pattern_shifter: loadable PAT_W-bit shift register that presents the
// pattern MSB first, with a bit index and a last-bit flag.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   load         : reload PATTERN and clear the index (has priority over shift)
//   shift        : advance to the next bit
//   msb          : current bit to transmit
//   last         : current bit is bit PAT_W-1 of the frame
module serial_pattern_shifter #(
  parameter int unsigned           PAT_W   = detector_pkg::PAT_W,
  parameter logic [PAT_W-1:0]      PATTERN = detector_pkg::PATTERN_1101
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic shift,
  output logic msb,
  output logic last
);

  localparam int unsigned IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

  logic [PAT_W-1:0] sr;
  logic [IDX_W-1:0] idx;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sr  <= '0;
      idx <= '0;
    end else if (load) begin
      sr  <= PATTERN;
      idx <= '0;
    end else if (shift) begin
      sr  <= sr << 1;
      idx <= idx + 1'b1;
    end
  end

  assign msb  = sr[PAT_W-1];
  assign last = (idx == IDX_W'(PAT_W - 1));

endmodule

// File: rtl/serial_pattern_gen1101.sv
// serial_pattern_gen1101: transmits PATTERN MSB first on a single-bit line,
// each copy preceded by a run of gap zeros, repeated a programmable number of
// times, with busy/done handshake. Outputs decode registered state only.
//   clock : rising-edge system clock
//   reset : asynchronous active-high reset, aborts transmission without done
//   bus   : slave side of serial_pattern_gen1101_if (start/gap/repeat_cnt in,
//           x/busy/done/bit_valid out)
module serial_pattern_gen1101
  import detector_pkg::*;
#(
  parameter int unsigned      PAT_W   = detector_pkg::PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = detector_pkg::PATTERN_1101,
  parameter int unsigned      CNT_W   = 4
) (
  input logic                      clock,
  input logic                      reset,
  serial_pattern_gen1101_if.slave  bus
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] gap_q;
  logic [CNT_W-1:0] gap_cnt;
  logic [CNT_W-1:0] rep_q;
  logic             load, shift, msb, last;

  serial_pattern_shifter #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN)
  ) u_shifter (
    .clock (clock),
    .reset (reset),
    .load  (load),
    .shift (shift),
    .msb   (msb),
    .last  (last)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (bus.start) state_nxt = (bus.gap != '0) ? ST_GAP : ST_SEND;
      ST_GAP:  if (gap_cnt == CNT_W'(1)) state_nxt = ST_SEND;
      ST_SEND: begin
        if (last) begin
          if (rep_q == CNT_W'(1))  state_nxt = ST_DONE;
          else if (gap_q != '0)    state_nxt = ST_GAP;
          else                     state_nxt = ST_SEND;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Reload on every SEND entry, including SEND->SEND for back-to-back frames.
  assign load  = (state_nxt == ST_SEND) && ((state != ST_SEND) || last);
  assign shift = (state == ST_SEND);

  // gap_cnt counts down the remaining zeros of the current gap; GAP exits
  // when it reads 1, so a gap of N occupies exactly N cycles without wrap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gap_q   <= '0;
      gap_cnt <= '0;
      rep_q   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bus.start) begin
            gap_q   <= bus.gap;
            gap_cnt <= bus.gap;
            rep_q   <= (bus.repeat_cnt == '0) ? CNT_W'(1) : bus.repeat_cnt;
          end
        end
        ST_GAP:  gap_cnt <= gap_cnt - 1'b1;
        ST_SEND: begin
          if (last) begin
            rep_q   <= rep_q - 1'b1;
            gap_cnt <= gap_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.x         = 1'b0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.bit_valid = 1'b0;
    unique case (state)
      ST_GAP:  bus.busy = 1'b1;
      ST_SEND: begin
        bus.x         = msb;
        bus.busy      = 1'b1;
        bus.bit_valid = 1'b1;
      end
      ST_DONE: bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule
